// File: rtl/iq_ctrl_pkg.sv
// Shared types and widths for the IQ stepped-frequency sweep controller.
package iq_ctrl_pkg;
  localparam int PHASE_W = 32;
  localparam int IQ_W    = 14;
  localparam int IDX_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;
endpackage

// File: rtl/iq_sweep_controller_if.sv
// Control, demodulator and result signals of the sweep controller.
interface iq_sweep_controller_if
  import iq_ctrl_pkg::*;
#(
  parameter int IW = IQ_W
) ();
  logic                      start;
  logic                      abort;
  logic [PHASE_W-1:0]        startInc;
  logic [PHASE_W-1:0]        stepInc;
  logic [IDX_W-1:0]          numPoints;
  logic [PHASE_W-1:0]        phaseInc;
  logic signed [IW-1:0]      I;
  logic signed [IW-1:0]      Q;
  logic [1:0]                filtValid;
  logic [3:0]                filtError;
  logic                      ncoValid;
  logic signed [IW-1:0]      resI;
  logic signed [IW-1:0]      resQ;
  logic [IDX_W-1:0]          resIndex;
  logic                      resErr;
  logic                      resValid;
  logic                      resReady;
  logic                      busy;
  logic                      done;

  modport master (
    output start, abort, startInc, stepInc, numPoints, I, Q, filtValid, filtError,
           ncoValid, resReady,
    input  phaseInc, resI, resQ, resIndex, resErr, resValid, busy, done
  );

  modport slave (
    input  start, abort, startInc, stepInc, numPoints, I, Q, filtValid, filtError,
           ncoValid, resReady,
    output phaseInc, resI, resQ, resIndex, resErr, resValid, busy, done
  );
endinterface

// File: rtl/iq_averager.sv
// Accumulates 2^AVG_LOG2 signed I/Q pairs and reports the floor-divided mean
// plus a sticky flag for any error seen while enabled.
module iq_averager
  import iq_ctrl_pkg::*;
#(
  parameter int IW       = IQ_W,
  parameter int AVG_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 sample_i,
  input  logic                 err_i,
  input  logic signed [IW-1:0] i_i,
  input  logic signed [IW-1:0] q_i,
  output logic signed [IW-1:0] avg_i_o,
  output logic signed [IW-1:0] avg_q_o,
  output logic                 full_o,
  output logic                 err_o
);
  localparam int AW = IW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] TARGET = CW'(1) << AVG_LOG2;

  logic signed [AW-1:0] sum_i_q, sum_i_d, sum_q_q, sum_q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 take_s;

  assign full_o  = (cnt_q == TARGET);
  assign take_s  = en_i & sample_i & ~full_o;
  assign avg_i_o = IW'(sum_i_q >>> AVG_LOG2);
  assign avg_q_o = IW'(sum_q_q >>> AVG_LOG2);
  assign err_o   = err_q;

  always_comb begin
    sum_i_d = sum_i_q;
    sum_q_d = sum_q_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (clr_i) begin
      sum_i_d = '0;
      sum_q_d = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (take_s) begin
        sum_i_d = sum_i_q + AW'(i_i);
        sum_q_d = sum_q_q + AW'(q_i);
        cnt_d   = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (en_i && err_i) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_i_q <= '0;
      sum_q_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      sum_i_q <= sum_i_d;
      sum_q_q <= sum_q_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: rtl/iq_sweep_controller.sv
// Stepped-frequency sweep sequencer: drives the NCO phase increment, waits for
// the demodulator to settle, averages I/Q and hands each point out on valid/ready.
module iq_sweep_controller
  import iq_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 256,
  parameter int AVG_LOG2      = 4,
  parameter int IW            = IQ_W
) (
  input logic                  CLK,
  input logic                  reset,
  iq_sweep_controller_if.slave bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [PHASE_W-1:0]   phase_q, phase_d, step_q, step_d;
  logic [IDX_W-1:0]     npts_q, npts_d, index_q, index_d;
  logic signed [IW-1:0] res_iv_q, res_iv_d, res_qv_q, res_qv_d;
  logic [IDX_W-1:0]     res_idx_q, res_idx_d;
  logic                 res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 avg_clr_s, avg_full_s, avg_err_s, err_now_s;
  logic signed [IW-1:0] avg_i_s, avg_q_s;

  assign err_now_s = |bus.filtError;

  iq_averager #(.IW(IW), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (CLK),
    .reset    (reset),
    .clr_i    (avg_clr_s),
    .en_i     (state_q == ST_ACCUM),
    .sample_i ((bus.filtValid == 2'b11) && bus.ncoValid),
    .err_i    (err_now_s),
    .i_i      (bus.I),
    .q_i      (bus.Q),
    .avg_i_o  (avg_i_s),
    .avg_q_o  (avg_q_s),
    .full_o   (avg_full_s),
    .err_o    (avg_err_s)
  );

  // Abort overrides everything; otherwise the state decides the next step.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    phase_d     = phase_q;
    step_d      = step_q;
    npts_d      = npts_q;
    index_d     = index_q;
    res_iv_d    = res_iv_q;
    res_qv_d    = res_qv_q;
    res_idx_d   = res_idx_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;
    avg_clr_s   = 1'b0;
    if (bus.abort) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && (bus.numPoints != 16'd0)) begin
            step_d   = bus.stepInc;
            npts_d   = bus.numPoints;
            phase_d  = bus.startInc;
            index_d  = 16'd0;
            settle_d = SETTLE_RELOAD;
            state_d  = ST_SETTLE;
          end else begin
            done_d = bus.start;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            avg_clr_s = 1'b1;
            res_err_d = 1'b0;
            state_d   = ST_ACCUM;
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end
        ST_ACCUM: begin
          if (avg_full_s) begin
            res_iv_d    = avg_i_s;
            res_qv_d    = avg_q_s;
            res_idx_d   = index_q;
            res_err_d   = avg_err_s | err_now_s;
            res_valid_d = 1'b1;
            state_d     = ST_OUTPUT;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_OUTPUT: begin
          if (bus.resReady) begin
            res_valid_d = 1'b0;
            if (index_q == (npts_q - 16'd1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              phase_d  = phase_q + step_q;
              index_d  = index_q + 16'd1;
              settle_d = SETTLE_RELOAD;
              state_d  = ST_SETTLE;
            end
          end else begin
            state_d = ST_OUTPUT;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      phase_q     <= '0;
      step_q      <= '0;
      npts_q      <= '0;
      index_q     <= '0;
      res_iv_q    <= '0;
      res_qv_q    <= '0;
      res_idx_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      phase_q     <= phase_d;
      step_q      <= step_d;
      npts_q      <= npts_d;
      index_q     <= index_d;
      res_iv_q    <= res_iv_d;
      res_qv_q    <= res_qv_d;
      res_idx_q   <= res_idx_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.phaseInc = phase_q;
  assign bus.resI     = res_iv_q;
  assign bus.resQ     = res_qv_q;
  assign bus.resIndex = res_idx_q;
  assign bus.resErr   = res_err_q;
  assign bus.resValid = res_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_iq_sweep_controller.sv
// Directed bench for iq_sweep_controller with SETTLE_CYCLES=8, AVG_LOG2=2.
module tb_iq_sweep_controller;
  logic CLK = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   valid_cnt = 0;
  int   n;
  int   d0;
  int   v0;

  iq_sweep_controller_if #(.IW(14)) bus ();

  iq_sweep_controller #(.SETTLE_CYCLES(8), .AVG_LOG2(2), .IW(14)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #40 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.resValid === 1'b1) valid_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_sweep(input logic [31:0] s_inc, input logic [31:0] st_inc,
                             input logic [15:0] np);
    bus.startInc  = s_inc;
    bus.stepInc   = st_inc;
    bus.numPoints = np;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (bus.resValid !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    chk(tag, 32'(bus.resValid), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.startInc  = 32'd0;
    bus.stepInc   = 32'd0;
    bus.numPoints = 16'd0;
    bus.I         = 14'sd100;
    bus.Q         = -14'sd100;
    bus.filtValid = 2'b11;
    bus.filtError = 4'b0000;
    bus.ncoValid  = 1'b1;
    bus.resReady  = 1'b1;
    tick();
    tick();
    chk("rst_phase", bus.phaseInc, 32'd0);
    chk("rst_valid", 32'(bus.resValid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_resI", 32'(bus.resI), 32'd0);
    chk("rst_index", 32'(bus.resIndex), 32'd0);
    reset = 1'b0;
    tick();

    // Basic three-point sweep
    d0 = done_cnt;
    start_sweep(32'h0100_0000, 32'h0010_0000, 16'd3);
    chk("b_busy", 32'(bus.busy), 32'd1);
    chk("b_phase0", bus.phaseInc, 32'h0100_0000);
    bus.startInc  = 32'hDEAD_0000;
    bus.stepInc   = 32'h0000_0001;
    bus.numPoints = 16'd9;
    wait_valid("b_v0", n);
    chk("b_latency", 32'(n + 1), 32'd14);
    chk("b_idx0", 32'(bus.resIndex), 32'd0);
    chk("b_resI0", 32'(bus.resI), 32'sd100);
    chk("b_resQ0", 32'(bus.resQ), -32'sd100);
    chk("b_err0", 32'(bus.resErr), 32'd0);
    tick();
    wait_valid("b_v1", n);
    chk("b_idx1", 32'(bus.resIndex), 32'd1);
    chk("b_phase1", bus.phaseInc, 32'h0110_0000);
    tick();
    wait_valid("b_v2", n);
    chk("b_idx2", 32'(bus.resIndex), 32'd2);
    chk("b_phase2", bus.phaseInc, 32'h0120_0000);
    chk("b_resQ2", 32'(bus.resQ), -32'sd100);
    tick();
    chk("b_done", 32'(bus.done), 32'd1);
    chk("b_busy_end", 32'(bus.busy), 32'd0);
    tick();
    chk("b_done_once", 32'(done_cnt - d0), 32'd1);
    chk("b_phase_hold", bus.phaseInc, 32'h0120_0000);

    // Averaging with gaps, then backpressure
    bus.filtValid = 2'b00;
    bus.resReady  = 1'b0;
    start_sweep(32'h0000_1000, 32'h0000_0100, 16'd2);
    for (int k = 0; k < 8; k++) tick();
    for (int k = 0; k < 4; k++) begin
      bus.I = (k == 0) ? 14'sd1 : 14'sd2;
      bus.Q = (k == 0) ? -14'sd1 : -14'sd2;
      bus.filtValid = 2'b11;
      bus.ncoValid  = 1'b1;
      tick();
      bus.I = 14'sd1000;
      bus.Q = 14'sd1000;
      bus.filtValid = 2'b01;
      tick();
      bus.filtValid = 2'b10;
      tick();
      bus.filtValid = 2'b11;
      bus.ncoValid  = 1'b0;
      tick();
      bus.ncoValid  = 1'b1;
      bus.filtValid = 2'b00;
    end
    bus.I = 14'sd100;
    bus.Q = -14'sd100;
    bus.filtValid = 2'b11;
    wait_valid("a_v0", n);
    chk("a_resI", 32'(bus.resI), 32'sd1);
    chk("a_resQ", 32'(bus.resQ), -32'sd2);
    chk("a_idx", 32'(bus.resIndex), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_valid", 32'(bus.resValid), 32'd1);
      chk("bp_resI", 32'(bus.resI), 32'sd1);
      chk("bp_resQ", 32'(bus.resQ), -32'sd2);
      chk("bp_idx", 32'(bus.resIndex), 32'd0);
      chk("bp_phase", bus.phaseInc, 32'h0000_1000);
    end
    bus.resReady = 1'b1;
    tick();
    chk("bp_released", 32'(bus.resValid), 32'd0);
    chk("bp_phase_step", bus.phaseInc, 32'h0000_1100);
    wait_valid("bp_v1", n);
    chk("bp_idx1", 32'(bus.resIndex), 32'd1);
    chk("bp_resI1", 32'(bus.resI), 32'sd100);
    tick();
    chk("bp_done", 32'(bus.done), 32'd1);

    // Phase increment wrap
    start_sweep(32'hFFFF_FF00, 32'h0000_0200, 16'd2);
    wait_valid("w_v0", n);
    chk("w_phase0", bus.phaseInc, 32'hFFFF_FF00);
    tick();
    wait_valid("w_v1", n);
    chk("w_phase1", bus.phaseInc, 32'h0000_0100);
    tick();
    chk("w_done", 32'(bus.done), 32'd1);
    tick();

    // Zero points
    start_sweep(32'h1234_5678, 32'h0000_0001, 16'd0);
    chk("z_done", 32'(bus.done), 32'd1);
    chk("z_busy", 32'(bus.busy), 32'd0);
    chk("z_phase", bus.phaseInc, 32'h0000_0100);
    tick();
    chk("z_done_clr", 32'(bus.done), 32'd0);
    chk("z_busy2", 32'(bus.busy), 32'd0);

    // Sticky error on one point only
    start_sweep(32'h0000_2000, 32'h0000_0010, 16'd2);
    for (int k = 0; k < 9; k++) tick();
    bus.filtError = 4'b0100;
    tick();
    bus.filtError = 4'b0000;
    wait_valid("e_v0", n);
    chk("e_err0", 32'(bus.resErr), 32'd1);
    chk("e_idx0", 32'(bus.resIndex), 32'd0);
    tick();
    wait_valid("e_v1", n);
    chk("e_err1", 32'(bus.resErr), 32'd0);
    chk("e_idx1", 32'(bus.resIndex), 32'd1);
    tick();
    chk("e_done", 32'(bus.done), 32'd1);
    tick();

    // start together with abort in IDLE
    bus.numPoints = 16'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("ai_busy", 32'(bus.busy), 32'd0);

    // Abort during SETTLE together with start
    start_sweep(32'h0300_0000, 32'h0000_0010, 16'd3);
    tick();
    tick();
    tick();
    d0 = done_cnt;
    v0 = valid_cnt;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_valid", 32'(bus.resValid), 32'd0);
    chk("ab_phase", bus.phaseInc, 32'h0300_0000);
    for (int k = 0; k < 40; k++) tick();
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ab_no_result", 32'(valid_cnt - v0), 32'd0);

    // Reset in the middle of ACCUM
    start_sweep(32'h0500_0000, 32'h0000_0010, 16'd2);
    for (int k = 0; k < 10; k++) tick();
    chk("r_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("r_phase", bus.phaseInc, 32'd0);
    chk("r_busy", 32'(bus.busy), 32'd0);
    chk("r_valid", 32'(bus.resValid), 32'd0);
    chk("r_done", 32'(bus.done), 32'd0);
    chk("r_resQ", 32'(bus.resQ), 32'd0);
    start_sweep(32'h0200_0000, 32'h0000_0010, 16'd1);
    wait_valid("r_v0", n);
    chk("r_latency", 32'(n + 1), 32'd14);
    chk("r_idx", 32'(bus.resIndex), 32'd0);
    chk("r_phase2", bus.phaseInc, 32'h0200_0000);
    chk("r_resI", 32'(bus.resI), 32'sd100);
    tick();
    chk("r_done2", 32'(bus.done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_sweep_controller.md
Name: iq_sweep_controller

Overview:
Sequences the IQ demodulator through a stepped-frequency sweep. For each point it drives the NCO phase increment and waits a fixed settling time for the NCO and FIR pipeline to flush. It then averages 2^AVG_LOG2 valid I/Q sample pairs and presents the averaged result on a valid/ready output. It sits between the host/control logic and the IQ module's phaseInc input and I/Q outputs.

Parameters:
SETTLE_CYCLES, 256, CLK cycles to wait after every phaseInc change before accumulating (covers NCO, mixer and FIR group delay); minimum 1
AVG_LOG2, 4, log2 of the number of valid I/Q pairs averaged per point; range 0..10
IW, 14, I/Q sample width (signed)

Ports:
CLK  in  1  system clock (12.5 MHz)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a sweep (accepted in IDLE only)
abort  in  1  synchronous abort of the sweep in progress
startInc  in  32  phase increment of point 0
stepInc  in  32  phase increment added per point (unsigned, mod 2^32)
numPoints  in  16  number of sweep points
phaseInc  out  32  registered phase increment to the NCO
I, Q  in  IW each  filtered demodulator outputs (signed)
filtValid  in  2  FIR source valid bits; a sample is used only when 2'b11
filtError  in  4  FIR source error bits
ncoValid  in  1  NCO output valid
resI, resQ  out  IW each  averaged I/Q of the current point (signed)
resIndex  out  16  point index of resI/resQ
resErr  out  1  set if any filtError bit was nonzero during this point's accumulation
resValid  out  1  result valid
resReady  in  1  consumer ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last point's result is accepted

Behaviour:
- Reset values: state IDLE; phaseInc, resI, resQ, resIndex, resErr, resValid, busy and done all 0.
- States: IDLE, SETTLE, ACCUM, OUTPUT.
- IDLE, start=1, numPoints>0: latch stepInc and numPoints; phaseInc<=startInc; index<=0; settle counter<=SETTLE_CYCLES-1; go to SETTLE.
- IDLE, start=1, numPoints=0: done pulses the next cycle; phaseInc unchanged; stay in IDLE.
- start outside IDLE is ignored. Input changes to startInc, stepInc or numPoints mid-sweep have no effect.
- SETTLE: decrement the counter each cycle. Transition to ACCUM in the cycle after the counter reads 0, so the dwell is exactly SETTLE_CYCLES cycles. The sample counter and the sums are cleared and resErr is cleared on entry to ACCUM.
- ACCUM:
  - When filtValid==2'b11 and ncoValid=1, add sign-extended I and Q into accumulators of width IW+AVG_LOG2 and increment the sample counter.
  - Cycles without a valid sample do not count.
  - Any cycle in ACCUM with filtError!=0 sets the resErr bit (sticky), whether or not a sample is taken that cycle.
  - After the 2^AVG_LOG2-th accepted sample, the next cycle enters OUTPUT with resI/resQ = sum >>> AVG_LOG2 (arithmetic shift, rounds toward minus infinity), resIndex=index and resValid=1.
- OUTPUT: resI, resQ, resIndex and resErr are held stable while resValid=1 and resReady=0. On resValid&resReady:
  - Last point (index==numPoints-1): resValid<=0, done pulses one cycle, go to IDLE. phaseInc keeps the last point's value.
  - Otherwise: resValid<=0, phaseInc<=phaseInc+stepInc (32-bit wrap, no saturation), index<=index+1, reload the settle counter, go to SETTLE.
- abort=1 in any state: go to IDLE next cycle; resValid<=0; no done pulse; phaseInc holds its current value. abort has priority over start and over the handshake in the same cycle.
- start and abort together in IDLE: abort wins and the sweep is not started.
- Accumulators never overflow because their width is IW+AVG_LOG2. The wrap of phaseInc is intentional.
- Latency from start to the first resValid = 1 + SETTLE_CYCLES + (cycles needed to collect 2^AVG_LOG2 valid samples) + 1.

Decomposition:
- Shared package iq_ctrl_pkg:
  - state enum (IDLE, SETTLE, ACCUM, OUTPUT)
  - phase-increment width constant (32)
  - IQ sample width constant (14)
- One sub-module, iq_averager: clear/enable inputs, signed I/Q accumulate, sample counter, count-reached flag, shifted outputs and the sticky error flag. The top level keeps the FSM, settle counter, phaseInc register and handshake.

Test Plan:
- Basic sweep: SETTLE_CYCLES=8, AVG_LOG2=2, startInc=32'h0100_0000, stepInc=32'h0010_0000, numPoints=3, I=100, Q=-100 constant, filtValid=11, resReady=1 -> three results with resIndex 0,1,2 and resI=100, resQ=-100. phaseInc steps 0100_0000 -> 0110_0000 -> 0120_0000. done pulses once; first resValid appears 14 cycles after start.
- Averaging/rounding: AVG_LOG2=2, I sequence 1,2,2,2 and Q sequence -1,-2,-2,-2 with filtValid gaps of 3 cycles between samples -> resI=1, resQ=-2. Gap cycles are not counted.
- Backpressure: hold resReady=0 for 20 cycles in OUTPUT -> resI, resQ and resIndex stable, phaseInc unchanged, no SETTLE entry until the handshake.
- Wrap and zero points: startInc=32'hFFFF_FF00, stepInc=32'h0000_0200, numPoints=2 -> second point phaseInc=32'h0000_0100. Separately, numPoints=0 -> done pulse, busy never asserted.
- Abort/error: assert filtError=4'b0100 for one ACCUM cycle -> that point has resErr=1 and the next point has resErr=0. Assert abort during SETTLE together with start -> IDLE next cycle, no done pulse, no further results.
- Reset mid-sweep: assert reset during ACCUM -> next cycle all outputs 0 and state IDLE. A subsequent start runs a clean sweep from index 0.
